// File: rtl/button_events_pkg.sv
// Shared types and helpers for the push-button conditioning path.
package button_events_pkg;

  // Debounce FSM states, one instance per button channel
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // Bits needed to count 0..n-1, never less than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce FSM, hold timer and registered strobes.
module button_channel
  import button_events_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic but,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HW = cnt_width(LONG_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic          IDLE_PIN  = ACTIVE_LOW;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic          s1, s2;
  logic          p;
  logic          level_n, press_n, release_n, long_n;

  assign p = s2 ^ ACTIVE_LOW;

  // Next-state, counter and strobe decode
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hcnt_n    = hcnt;
    level_n   = level;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;

    // hold timer runs for as long as the debounced level is pressed
    if ((state == ST_PRESSED || state == ST_RELEASE_WAIT) && hcnt != HOLD_LAST) begin
      hcnt_n = hcnt + HW'(1);
      long_n = (hcnt_n == HOLD_LAST);
    end

    case (state)
      ST_IDLE: begin
        if (p) begin
          state_n = ST_PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!p) begin
          state_n = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_PRESSED;
          press_n = 1'b1;
          level_n = 1'b1;
          hcnt_n  = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_PRESSED: begin
        if (!p) begin
          state_n = ST_RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        // a bounce back to pressed keeps the hold time and emits no press
        if (p) begin
          state_n = ST_PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_n   = ST_IDLE;
          release_n = 1'b1;
          level_n   = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, counters, synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= IDLE_PIN;
      s2            <= IDLE_PIN;
      state         <= ST_IDLE;
      cnt           <= '0;
      hcnt          <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      s1            <= but;
      s2            <= s1;
      state         <= state_n;
      cnt           <= cnt_n;
      hcnt          <= hcnt_n;
      level         <= level_n;
      press         <= press_n;
      release_pulse <= release_n;
      long_press    <= long_n;
    end
  end

endmodule

// File: rtl/button_events.sv
// Conditions NUM_BUT raw push-buttons into debounced levels and event strobes.
// The release strobe is named release_pulse because "release" is a reserved word.
module button_events
  import button_events_pkg::*;
#(
  parameter int unsigned NUM_BUT         = 2,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BUT-1:0] but,
  output logic [NUM_BUT-1:0] level,
  output logic [NUM_BUT-1:0] press,
  output logic [NUM_BUT-1:0] release_pulse,
  output logic [NUM_BUT-1:0] long_press
);

  // One fully independent channel per button
  for (genvar i = 0; i < int'(NUM_BUT); i++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .but          (but[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i])
    );
  end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with a behavioural run-length model.
module tb_button_events;

  localparam int D = 4;
  localparam int L = 20;

  logic       clk;
  logic       rst;
  logic [1:0] but;
  logic [1:0] level, press, rel, long_press;

  button_events #(
    .NUM_BUT(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)
  ) dut (
    .clk(clk), .rst(rst), .but(but), .level(level), .press(press),
    .release_pulse(rel), .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check_vec(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: the pressed sense arrives two edges late; a change is accepted once
  // D+1 consecutive opposite samples are seen; hold age counts while pressed.
  logic       m_d1 [2];
  logic       m_d2 [2];
  logic       m_p;
  int         m_run [2];
  int         m_age [2];
  logic [1:0] m_lvl, m_press, m_rel, m_long;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_press[i] = 1'b0;
      m_rel[i]   = 1'b0;
      m_long[i]  = 1'b0;
      if (rst) begin
        m_d1[i]  = 1'b0;
        m_d2[i]  = 1'b0;
        m_lvl[i] = 1'b0;
        m_run[i] = 0;
        m_age[i] = 0;
      end else begin
        m_p     = m_d2[i];
        m_d2[i] = m_d1[i];
        m_d1[i] = ~but[i];
        if (m_lvl[i] && m_age[i] < L - 1) begin
          m_age[i]++;
          if (m_age[i] == L - 1) m_long[i] = 1'b1;
        end
        if (m_p != m_lvl[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == D + 1) begin
          m_run[i] = 0;
          m_lvl[i] = ~m_lvl[i];
          if (m_lvl[i]) begin
            m_press[i] = 1'b1;
            m_age[i]   = 0;
          end else begin
            m_rel[i] = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check_vec("level", level, m_lvl);
      check_vec("press", press, m_press);
      check_vec("release", rel, m_rel);
      check_vec("long_press", long_press, m_long);
    end
  end

  // Per-scenario tallies of channel-0 events and any channel-1 activity
  int edge_no, press_edge, rel_edge, long_edge;
  int n_press0, n_rel0, n_long0, n_ch1;

  task automatic clear_tally();
    edge_no = 0; press_edge = -1; rel_edge = -1; long_edge = -1;
    n_press0 = 0; n_rel0 = 0; n_long0 = 0; n_ch1 = 0;
  endtask

  task automatic step(input logic r, input logic [1:0] b);
    rst = r;
    but = b;
    @(negedge clk);
    edge_no++;
    if (press[0] === 1'b1) begin n_press0++; if (press_edge < 0) press_edge = edge_no; end
    if (rel[0] === 1'b1) begin n_rel0++; if (rel_edge < 0) rel_edge = edge_no; end
    if (long_press[0] === 1'b1) begin n_long0++; if (long_edge < 0) long_edge = edge_no; end
    if (press[1] !== 1'b0 || rel[1] !== 1'b0 || long_press[1] !== 1'b0 || level[1] !== 1'b0)
      n_ch1++;
  endtask

  logic [1:0] t3_pat [8];
  logic [1:0] t5_pat [6];

  initial begin
    rst = 1'b1;
    but = 2'b11;
    clear_tally();
    @(negedge clk);

    // 1: reset with buttons idle, then a quiet period
    step(1'b1, 2'b11);
    chk_en = 1'b1;
    check_vec("t1_reset_level", level, 2'b00);
    step(1'b1, 2'b11);
    step(1'b1, 2'b11);
    clear_tally();
    for (int k = 0; k < 50; k++) step(1'b0, 2'b11);
    check_int("t1_quiet", n_press0 + n_rel0 + n_long0 + n_ch1, 0);

    // 2 + 4: clean press of button 0, held long enough for one long press
    clear_tally();
    for (int k = 0; k < 50; k++) step(1'b0, 2'b10);
    check_int("t2_press_edge", press_edge, 7);
    check_int("t2_press_count", n_press0, 1);
    check_int("t2_ch1_silent", n_ch1, 0);
    check_vec("t2_level", level, 2'b01);
    check_int("t4_long_edge", long_edge, 26);
    check_int("t4_long_count", n_long0, 1);

    // 5: release with bounce
    clear_tally();
    t5_pat = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    for (int k = 0; k < 6; k++) step(1'b0, t5_pat[k]);
    for (int k = 0; k < 20; k++) step(1'b0, 2'b11);
    check_int("t5_release_edge", rel_edge, 9);
    check_int("t5_release_count", n_rel0, 1);
    check_int("t5_no_press", n_press0, 0);
    check_vec("t5_level", level, 2'b00);

    // 3: bouncy press
    clear_tally();
    t3_pat = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    for (int k = 0; k < 8; k++) step(1'b0, t3_pat[k]);
    for (int k = 0; k < 22; k++) step(1'b0, 2'b10);
    check_int("t3_press_edge", press_edge, 14);
    check_int("t3_press_count", n_press0, 1);

    // 6: reset while held, then a fresh press
    clear_tally();
    step(1'b1, 2'b10);
    check_vec("t6_reset_level", level, 2'b00);
    edge_no = 0;
    press_edge = -1;
    for (int k = 0; k < 12; k++) step(1'b0, 2'b10);
    check_int("t6_press_edge", press_edge, 7);
    check_int("t6_no_release", n_rel0, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
